// File: rtl/btb_gshare_predictor_if.sv
// Fetch/resolve bundle between the pipeline and btb_gshare_predictor.
// The pipeline drives through the master modport and the predictor answers through the slave modport.
interface btb_gshare_predictor_if #(
  parameter int WORD_SIZE = 16,
  parameter int IDX_BITS  = 8,
  parameter int STAT_BITS = 16
);
  logic                 bp_flush;
  logic                 bp_ready;
  logic [WORD_SIZE-1:0] pc;
  logic [WORD_SIZE-1:0] next_pc;
  logic                 pred_taken;
  logic [IDX_BITS-1:0]  pred_idx;
  logic                 upd_valid;
  logic [WORD_SIZE-1:0] upd_pc;
  logic [IDX_BITS-1:0]  upd_idx;
  logic                 upd_is_cond;
  logic                 upd_is_jump;
  logic                 upd_taken;
  logic [WORD_SIZE-1:0] upd_target;
  logic                 upd_mispredict;
  logic [STAT_BITS-1:0] stat_branches;
  logic [STAT_BITS-1:0] stat_mispred;

  modport master (
    output bp_flush, pc, upd_valid, upd_pc, upd_idx, upd_is_cond, upd_is_jump,
           upd_taken, upd_target, upd_mispredict,
    input  bp_ready, next_pc, pred_taken, pred_idx, stat_branches, stat_mispred
  );

  modport slave (
    input  bp_flush, pc, upd_valid, upd_pc, upd_idx, upd_is_cond, upd_is_jump,
           upd_taken, upd_target, upd_mispredict,
    output bp_ready, next_pc, pred_taken, pred_idx, stat_branches, stat_mispred
  );
endinterface

// File: rtl/btb_gshare_predictor.sv
// Tagged BTB plus saturating-counter pattern table, optionally gshare-indexed by resolve-time history.
// Predicts combinationally from the fetch PC; trains from the one-cycle resolve update port.
module btb_gshare_predictor #(
  parameter int WORD_SIZE = 16,
  parameter int IDX_BITS  = 8,
  parameter int TAG_BITS  = 8,
  parameter int CTR_BITS  = 2,
  parameter int GHR_BITS  = 0,
  parameter int STAT_BITS = 16
) (
  input logic                   clk,
  input logic                   reset,
  btb_gshare_predictor_if.slave bp
);
  localparam int ENTRIES = 1 << IDX_BITS;
  localparam int GHR_W   = (GHR_BITS > 0) ? GHR_BITS : 1;
  localparam logic [CTR_BITS-1:0] CTR_WEAK_NT = CTR_BITS'((1 << (CTR_BITS - 1)) - 1);
  localparam logic [CTR_BITS-1:0] CTR_MAX     = '1;

  typedef enum logic {S_INIT, S_RUN} state_t;

  state_t               r_state, w_state_next;
  logic [IDX_BITS-1:0]  r_clr_ptr, w_clr_ptr_next;
  logic [GHR_W-1:0]     r_ghr;
  logic [STAT_BITS-1:0] r_stat_br, r_stat_mp;

  logic                 r_valid  [ENTRIES];
  logic                 r_uncond [ENTRIES];
  logic [TAG_BITS-1:0]  r_tag    [ENTRIES];
  logic [WORD_SIZE-1:0] r_target [ENTRIES];
  logic [CTR_BITS-1:0]  r_ctr    [ENTRIES];

  logic [IDX_BITS-1:0]  w_bidx, w_pidx, w_hist, w_ubidx;
  logic [TAG_BITS-1:0]  w_tag, w_utag;
  logic                 w_hit, w_taken, w_upd, w_btb_we;
  logic [CTR_BITS-1:0]  w_ctr_cur, w_ctr_next;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_INIT;
      r_clr_ptr <= '0;
    end else begin
      r_state   <= w_state_next;
      r_clr_ptr <= w_clr_ptr_next;
    end
  end

  always_comb begin
    w_state_next   = r_state;
    w_clr_ptr_next = r_clr_ptr;
    if (bp.bp_flush) begin
      w_state_next   = S_INIT;
      w_clr_ptr_next = '0;
    end else if (r_state == S_INIT) begin
      w_clr_ptr_next = r_clr_ptr + 1'b1;
      if (r_clr_ptr == '1) w_state_next = S_RUN;
    end
  end

  always_comb begin
    w_hist = '0;
    if (GHR_BITS > 0) w_hist[GHR_W-1:0] = r_ghr;
  end

  assign w_bidx  = bp.pc[IDX_BITS-1:0];
  assign w_pidx  = w_bidx ^ w_hist;
  assign w_tag   = bp.pc[IDX_BITS+TAG_BITS-1:IDX_BITS];
  assign w_hit   = r_valid[w_bidx] && (r_tag[w_bidx] == w_tag);
  assign w_taken = (r_state == S_RUN) && w_hit && (r_uncond[w_bidx] || r_ctr[w_pidx][CTR_BITS-1]);

  assign bp.bp_ready      = (r_state == S_RUN);
  assign bp.pred_taken    = w_taken;
  assign bp.next_pc       = w_taken ? r_target[w_bidx] : bp.pc + WORD_SIZE'(1);
  assign bp.pred_idx      = w_pidx;
  assign bp.stat_branches = r_stat_br;
  assign bp.stat_mispred  = r_stat_mp;

  assign w_upd     = (r_state == S_RUN) && bp.upd_valid;
  assign w_ubidx   = bp.upd_pc[IDX_BITS-1:0];
  assign w_utag    = bp.upd_pc[IDX_BITS+TAG_BITS-1:IDX_BITS];
  assign w_btb_we  = bp.upd_is_cond ? bp.upd_taken : bp.upd_is_jump;
  assign w_ctr_cur = r_ctr[bp.upd_idx];

  always_comb begin
    w_ctr_next = w_ctr_cur;
    if (bp.upd_taken && w_ctr_cur != CTR_MAX)       w_ctr_next = w_ctr_cur + 1'b1;
    else if (!bp.upd_taken && w_ctr_cur != '0)      w_ctr_next = w_ctr_cur - 1'b1;
  end

  // NOTE: the tables carry no reset branch; the init FSM clears one entry per cycle instead,
  // so they map onto plain RAM with no per-bit reset fan-out.
  always_ff @(posedge clk) begin
    if (r_state == S_INIT) begin
      r_valid[r_clr_ptr]  <= 1'b0;
      r_uncond[r_clr_ptr] <= 1'b0;
      r_tag[r_clr_ptr]    <= '0;
      r_target[r_clr_ptr] <= '0;
      r_ctr[r_clr_ptr]    <= CTR_WEAK_NT;
    end else if (w_upd) begin
      if (bp.upd_is_cond) r_ctr[bp.upd_idx] <= w_ctr_next;
      if (w_btb_we) begin
        r_valid[w_ubidx]  <= 1'b1;
        r_uncond[w_ubidx] <= !bp.upd_is_cond;
        r_tag[w_ubidx]    <= w_utag;
        r_target[w_ubidx] <= bp.upd_target;
      end
    end
  end

  // History and statistics survive a flush; only reset clears them.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ghr     <= '0;
      r_stat_br <= '0;
      r_stat_mp <= '0;
    end else if (w_upd) begin
      if (GHR_BITS > 0 && bp.upd_is_cond) r_ghr <= (r_ghr << 1) | GHR_W'(bp.upd_taken);
      if (r_stat_br != '1) r_stat_br <= r_stat_br + 1'b1;
      if (bp.upd_mispredict && r_stat_mp != '1) r_stat_mp <= r_stat_mp + 1'b1;
    end
  end
endmodule

// File: tb/tb_btb_gshare_predictor.sv
// Bench for btb_gshare_predictor: a bimodal instance and a 4-bit gshare instance share one stimulus
// stream and are compared every cycle against an array-based model of the predictor's rules.
module tb_btb_gshare_predictor;
  localparam int N = 256;

  logic        clk = 1'b0;
  logic        reset, flush;
  logic [15:0] pc, upd_pc, upd_target;
  logic [7:0]  upd_idx;
  logic        upd_valid, upd_cond, upd_jump, upd_taken, upd_misp;

  always #5 clk = ~clk;

  btb_gshare_predictor_if #(.WORD_SIZE(16), .IDX_BITS(8), .STAT_BITS(16)) bpa ();
  btb_gshare_predictor_if #(.WORD_SIZE(16), .IDX_BITS(8), .STAT_BITS(5))  bpb ();

  assign bpa.bp_flush = flush;          assign bpb.bp_flush = flush;
  assign bpa.pc = pc;                   assign bpb.pc = pc;
  assign bpa.upd_valid = upd_valid;     assign bpb.upd_valid = upd_valid;
  assign bpa.upd_pc = upd_pc;           assign bpb.upd_pc = upd_pc;
  assign bpa.upd_idx = upd_idx;         assign bpb.upd_idx = upd_idx;
  assign bpa.upd_is_cond = upd_cond;    assign bpb.upd_is_cond = upd_cond;
  assign bpa.upd_is_jump = upd_jump;    assign bpb.upd_is_jump = upd_jump;
  assign bpa.upd_taken = upd_taken;     assign bpb.upd_taken = upd_taken;
  assign bpa.upd_target = upd_target;   assign bpb.upd_target = upd_target;
  assign bpa.upd_mispredict = upd_misp; assign bpb.upd_mispredict = upd_misp;

  btb_gshare_predictor #(.GHR_BITS(0), .STAT_BITS(16)) u_bimodal (
    .clk(clk), .reset(reset), .bp(bpa.slave));
  btb_gshare_predictor #(.GHR_BITS(4), .STAT_BITS(5)) u_gshare (
    .clk(clk), .reset(reset), .bp(bpb.slave));

  // Reference model, one copy per instance (0 = bimodal, 1 = gshare).
  int          gbits [2] = '{0, 4};
  int          smax  [2] = '{65535, 31};
  bit          known = 1'b0;
  int          m_rem [2];
  int          m_ghr [2];
  int          m_br  [2];
  int          m_mp  [2];
  bit          m_valid  [2][N];
  bit          m_uncond [2][N];
  int          m_tag    [2][N];
  int          m_target [2][N];
  int          m_ctr    [2][N];

  int n_cmp = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_check(input int k);
    int  b, p;
    bit  t;
    logic [15:0] nxt;
    b   = int'(pc[7:0]);
    p   = b ^ m_ghr[k];
    t   = (m_rem[k] == 0) && m_valid[k][b] && (m_tag[k][b] == int'(pc[15:8])) &&
          (m_uncond[k][b] || m_ctr[k][p] >= 2);
    nxt = t ? 16'(m_target[k][b]) : 16'(pc + 16'd1);
    if (k == 0) begin
      chk("a_ready", bpa.bp_ready, (m_rem[0] == 0));
      chk("a_taken", bpa.pred_taken, t);
      chk("a_next_pc", bpa.next_pc, nxt);
      chk("a_pred_idx", bpa.pred_idx, p);
      chk("a_stat_br", bpa.stat_branches, m_br[0]);
      chk("a_stat_mp", bpa.stat_mispred, m_mp[0]);
    end else begin
      chk("b_ready", bpb.bp_ready, (m_rem[1] == 0));
      chk("b_taken", bpb.pred_taken, t);
      chk("b_next_pc", bpb.next_pc, nxt);
      chk("b_pred_idx", bpb.pred_idx, p);
      chk("b_stat_br", bpb.stat_branches, m_br[1]);
      chk("b_stat_mp", bpb.stat_mispred, m_mp[1]);
    end
  endtask

  task automatic model_step(input int k);
    int ub, ui;
    ub = int'(upd_pc[7:0]);
    ui = int'(upd_idx);
    if (reset) begin
      m_rem[k] = N; m_ghr[k] = 0; m_br[k] = 0; m_mp[k] = 0;
      return;
    end
    if (m_rem[k] == 0 && upd_valid) begin
      if (upd_cond) begin
        m_ctr[k][ui] = upd_taken ? ((m_ctr[k][ui] < 3) ? m_ctr[k][ui] + 1 : 3)
                                 : ((m_ctr[k][ui] > 0) ? m_ctr[k][ui] - 1 : 0);
        if (gbits[k] > 0) m_ghr[k] = ((m_ghr[k] * 2) + int'(upd_taken)) % (1 << gbits[k]);
      end
      if (upd_cond ? upd_taken : upd_jump) begin
        m_valid[k][ub]  = 1'b1;
        m_uncond[k][ub] = !upd_cond;
        m_tag[k][ub]    = int'(upd_pc[15:8]);
        m_target[k][ub] = int'(upd_target);
      end
      if (m_br[k] < smax[k]) m_br[k]++;
      if (upd_misp && m_mp[k] < smax[k]) m_mp[k]++;
    end
    if (flush) m_rem[k] = N;
    else if (m_rem[k] > 0) begin
      m_rem[k]--;
      if (m_rem[k] == 0)
        for (int e = 0; e < N; e++) begin
          m_valid[k][e] = 0; m_uncond[k][e] = 0; m_tag[k][e] = 0; m_target[k][e] = 0; m_ctr[k][e] = 1;
        end
    end
  endtask

  // Inputs are set at a falling edge; outputs are compared 1 ns later, then the clock advances.
  task automatic tick();
    #1;
    if (known) begin model_check(0); model_check(1); end
    model_step(0);
    model_step(1);
    if (reset) known = 1'b1;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    upd_valid = 0; upd_cond = 0; upd_jump = 0; upd_taken = 0; upd_misp = 0; flush = 0;
  endtask

  task automatic upd(input logic [15:0] p, input logic [7:0] idx, input logic c, input logic j,
                     input logic t, input logic [15:0] tgt, input logic mp);
    upd_valid = 1; upd_pc = p; upd_idx = idx; upd_cond = c; upd_jump = j;
    upd_taken = t; upd_target = tgt; upd_misp = mp;
    tick();
    idle();
  endtask

  initial begin
    reset = 1; pc = 16'h0010; upd_pc = 0; upd_idx = 0; upd_target = 0;
    idle();
    @(negedge clk);
    tick(); tick();
    reset = 0;

    // Reset and init sequence with default outputs.
    for (int i = 0; i < N; i++) begin
      if (i == 5) begin #1; chk("init_next_pc", bpa.next_pc, 16'h0011); chk("init_taken", bpa.pred_taken, 0); end
      tick();
    end
    #1; chk("ready_after_init", bpa.bp_ready, 1'b1);

    // Counter training and saturation on the bimodal instance.
    upd(16'h0020, 8'h20, 1, 0, 1, 16'h0040, 1);
    pc = 16'h0020; #1;
    chk("train_taken", bpa.pred_taken, 1'b1);
    chk("train_target", bpa.next_pc, 16'h0040);
    tick();
    upd(16'h0020, 8'h20, 1, 0, 0, 16'h0040, 1);
    upd(16'h0020, 8'h20, 1, 0, 0, 16'h0040, 0);
    #1; chk("two_nt", bpa.pred_taken, 1'b0);
    upd(16'h0020, 8'h20, 1, 0, 0, 16'h0040, 0);
    upd(16'h0020, 8'h20, 1, 0, 1, 16'h0040, 0);
    #1; chk("sat_low", bpa.pred_taken, 1'b0);

    // Tag alias: same index, different tag field.
    upd(16'h0120, 8'h20, 1, 0, 1, 16'h0077, 0);
    pc = 16'h0220; #1;
    chk("alias_miss", bpa.pred_taken, 1'b0);
    chk("alias_next", bpa.next_pc, 16'h0221);
    tick();

    // Unconditional jump ignores the weak-not-taken counter.
    upd(16'h0030, 8'h30, 0, 1, 0, 16'h0005, 1);
    pc = 16'h0030; #1;
    chk("jump_taken", bpa.pred_taken, 1'b1);
    chk("jump_target", bpa.next_pc, 16'h0005);
    tick();
    pc = 16'hFFFF; #1;
    chk("pc_wrap", bpa.next_pc, 16'h0000);
    tick();

    // Gshare history 1,0,1,1.
    upd(16'h0040, 8'h40, 1, 0, 1, 16'h0100, 0);
    upd(16'h0041, 8'h41, 1, 0, 0, 16'h0100, 0);
    upd(16'h0042, 8'h42, 1, 0, 1, 16'h0100, 0);
    upd(16'h0043, 8'h43, 1, 0, 1, 16'h0100, 0);
    pc = 16'h0000; #1;
    chk("gshare_idx", bpb.pred_idx, 8'h0B);
    chk("bimodal_idx", bpa.pred_idx, 8'h00);
    tick();
    upd(16'h0000, 8'h0B, 1, 0, 1, 16'h0200, 0);
    tick();

    // Flush at clr_ptr 100, then reset mid-init, with updates offered throughout.
    flush = 1; tick(); flush = 0;
    for (int i = 0; i < 100; i++) begin upd_valid = 1; upd_cond = 1; upd_taken = 1; tick(); end
    flush = 1; tick(); flush = 0;
    for (int i = 0; i < 50; i++) tick();
    reset = 1; tick(); reset = 0;
    for (int i = 0; i < N; i++) begin upd_valid = i[0]; upd_cond = 1; upd_taken = 1; tick(); end
    idle();
    #1; chk("ready_after_reinit", bpa.bp_ready, 1'b1);

    // Randomised traffic over a small PC space so entries collide and hit often.
    for (int i = 0; i < 3000; i++) begin
      pc         = {8'($urandom_range(0, 1)), 8'($urandom_range(0, 15))};
      if ($urandom_range(0, 15) == 0) pc = 16'($urandom);
      upd_valid  = 1'($urandom);
      upd_pc     = {8'($urandom_range(0, 1)), 8'($urandom_range(0, 15))};
      upd_idx    = 8'($urandom_range(0, 15));
      upd_cond   = 1'($urandom);
      upd_jump   = ($urandom_range(0, 3) == 0);
      upd_taken  = 1'($urandom);
      upd_target = 16'($urandom);
      upd_misp   = 1'($urandom);
      flush      = ($urandom_range(0, 499) == 0);
      tick();
    end
    idle();
    #1; chk("stat_saturated", bpb.stat_branches, 5'h1F);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
